apb_master: RTL and testbench
=============================

# apb_master

APB requester that turns single-beat commands from a local command port into APB3 SETUP/ACCESS transfers and returns read data and error status on a response port. It is the initiator-side counterpart to the team's APB register-file slaves, sits between an internal controller or bus bridge and the APB segment, and supports slave wait states via PREADY.

## Interface
- ADDRESS_WIDTH, 5, APB address width
- DATA_WIDTH, 8, APB data width
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort (used only with APB_MASTER_TIMEOUT_EN)

Ports:
- PCLK  in  1  clock; one clock domain, all logic on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDRESS_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_err  out  1  PSLVERR captured at completion, or timeout
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDRESS_WIDTH; PWDATA  out  DATA_WIDTH
- PRDATA  in  DATA_WIDTH; PREADY, PSLVERR  in  1

## Operation
- FSM states IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1, PSEL=0, PENABLE=0. On accept: latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, go SETUP.
- SETUP: PSEL=1, PENABLE=0, cmd_ready=0; unconditionally go ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PREADY=1 → completion: go IDLE, register rsp_valid=1, rsp_err=PSLVERR, rsp_rdata = PWRITE ? 0 : PRDATA. PREADY=0 → stay (wait state).
- PADDR/PWRITE/PWDATA held stable from SETUP through completion; PWDATA forced 0 on reads.
- PRDATA and PSLVERR sampled only in the completion cycle (PSEL&PENABLE&PREADY); ignored in SETUP, wait states and IDLE (slaves may drive Z or assert PSLVERR outside completion).
- No pipelining: one outstanding transfer; commands presented while cmd_ready=0 are held by the requester.

## Timing
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; state IDLE so cmd_ready=1 once PRESETn high.
- Accept at edge k → SETUP cycle k..k+1 → ACCESS from k+1; zero-wait completion at edge k+2; rsp_valid high for cycle k+2..k+3; next command accepted earliest at edge k+3 (3-cycle period).
- N wait states add N cycles; rsp_valid never exceeds one cycle per transfer.
- rsp_rdata/rsp_err hold their last value after rsp_valid drops, until the next completion.
- PRESETn assertion mid-transfer: immediate return to reset values, transfer dropped, no rsp_valid.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: counter counts ACCESS cycles with PREADY=0; when it reaches TIMEOUT_CYCLES, abort: PSEL/PENABLE drop next edge, state IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0. Counter clears on each SETUP.
- Undefined: no counter; master waits indefinitely for PREADY; TIMEOUT_CYCLES unused.

## Structure
- Shared package apb_pkg: apb_state_t enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10), default ADDRESS_WIDTH/DATA_WIDTH constants.
- One sub-module apb_timeout_counter (enable, clear, terminal-count output, width $clog2(TIMEOUT_CYCLES+1)), instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write addr 5'h03 data 8'hA5, PREADY tied 1 → PSEL high 2 cycles, PENABLE 1 cycle, PADDR=03, PWDATA=A5; rsp_valid one cycle later, rsp_err=0.
- Read addr 5'h1F, slave returns 8'h3C with 2 wait states → ACCESS lasts 3 cycles, PADDR stable, rsp_rdata=3C.
- Read with PSLVERR high in SETUP only, low at completion → rsp_err=0; PSLVERR high at completion → rsp_err=1.
- Back-to-back cmd_valid held high for 4 commands, zero wait → accepts every 3 cycles, 4 rsp_valid pulses in order.
- PRESETn pulsed low during ACCESS → PSEL/PENABLE 0 immediately, no rsp_valid, cmd_ready=1 after release.
- APB_MASTER_TIMEOUT_EN, PREADY stuck 0 → abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, back to IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 5;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts enabled cycles; tc_o flags the enabled cycle that is the TIMEOUT_CYCLES-th since clear.
module apb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == CntLast);

endmodule

// File: rtl/apb_master.sv
// APB3 requester: single-beat command port to SETUP/ACCESS transfers with a response pulse.
// Optional ACCESS wait-state abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = APB_ADDR_W,
    parameter int unsigned DATA_WIDTH     = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ADDRESS_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0]    PWDATA,
    input  logic [DATA_WIDTH-1:0]    PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    apb_state_t                 state_q, state_d;
    logic                       pwrite_q, pwrite_d;
    logic [ADDRESS_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic                       rsp_err_q, rsp_err_d;
    logic                       timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i  (PCLK),
        .rst_ni (PRESETn),
        .en_i   ((state_q == ACCESS) && !PREADY),
        .clr_i  (state_q == SETUP),
        .tc_o   (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d  = SETUP;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // PRDATA/PSLVERR are only trusted in the PREADY cycle.
                if (PREADY) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end else if (timeout) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign PSEL      = (state_q != IDLE);
    assign PENABLE   = (state_q == ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: cycle-count transfer model plus hand-computed pins.
module tb_apb_master;

    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          PCLK      = 1'b0;
    logic          PRESETn   = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          cmd_ready, rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata, PWDATA, PRDATA;
    logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] rdata;
        logic          err;
        logic          noise;
    } ent_t;

    ent_t tbl [11];

    int total   = 0;
    int bad     = 0;
    int cyc     = 0;
    int drv_idx = 0;

    // Slave side: behaviour of the currently selected table entry.
    int            s_waits = 0;
    logic [DW-1:0] s_rdata = '0;
    logic          s_err   = 1'b0;
    logic          s_noise = 1'b0;
    int            acc_cnt = 0;

    apb_master #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    assign PREADY  = PSEL && PENABLE && (acc_cnt == s_waits);
    assign PRDATA  = PREADY ? s_rdata : 8'hEE;
    assign PSLVERR = PREADY ? s_err : (PSEL && !PENABLE && s_noise);

    always @(posedge PCLK) acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transfer model: a transfer accepted in cycle c shows SETUP in c+1, then ACCESS
    // for waits+1 cycles (or TMO cycles when aborting), then a one-cycle response.
    logic          m_busy = 1'b0;
    logic          m_rsp  = 1'b0;
    logic          m_er   = 1'b0;
    logic [DW-1:0] m_rd   = '0;
    int            m_age  = 0;
    ent_t          m_cur;
    int            n_psel = 0;
    int            n_pen  = 0;
    int            acc_log[$];
    int            psel_log[$];
    int            pen_log[$];
    int            rsp_cy[$];
    logic [DW-1:0] rsp_rd[$];
    logic          rsp_er[$];

    always @(negedge PCLK) begin
        logic fin, tmo;
        cyc++;
        if (!PRESETn) begin
            chk("rst_psel", 32'(PSEL), 0);
            chk("rst_penable", 32'(PENABLE), 0);
            chk("rst_pwrite", 32'(PWRITE), 0);
            chk("rst_paddr", 32'(PADDR), 0);
            chk("rst_pwdata", 32'(PWDATA), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
            chk("rst_rsp_err", 32'(rsp_err), 0);
            m_busy = 1'b0;
            m_rsp  = 1'b0;
            m_er   = 1'b0;
            m_rd   = '0;
        end else begin
            chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
            chk("psel", 32'(PSEL), 32'(m_busy));
            chk("penable", 32'(PENABLE), 32'(m_busy && (m_age >= 1)));
            if (m_busy) begin
                chk("paddr", 32'(PADDR), 32'(m_cur.addr));
                chk("pwrite", 32'(PWRITE), 32'(m_cur.wr));
                chk("pwdata", 32'(PWDATA), m_cur.wr ? 32'(m_cur.wdata) : 0);
                if (PSEL) n_psel++;
                if (PENABLE) n_pen++;
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rd));
            chk("rsp_err", 32'(rsp_err), 32'(m_er));
            if (rsp_valid) begin
                rsp_cy.push_back(cyc);
                rsp_rd.push_back(rsp_rdata);
                rsp_er.push_back(rsp_err);
            end
            m_rsp = 1'b0;
            if (m_busy) begin
                fin = (m_age >= 1) && (m_age - 1 == m_cur.waits);
                tmo = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
                tmo = !fin && (m_age == TMO);
`endif
                if (fin || tmo) begin
                    m_busy = 1'b0;
                    m_rsp  = 1'b1;
                    m_er   = tmo ? 1'b1 : m_cur.err;
                    m_rd   = (tmo || m_cur.wr) ? '0 : m_cur.rdata;
                    psel_log.push_back(n_psel);
                    pen_log.push_back(n_pen);
                end else begin
                    m_age++;
                end
            end else if (cmd_valid) begin
                m_busy  = 1'b1;
                m_age   = 0;
                m_cur   = tbl[drv_idx];
                n_psel  = 0;
                n_pen   = 0;
                s_waits = m_cur.waits;
                s_rdata = m_cur.rdata;
                s_err   = m_cur.err;
                s_noise = m_cur.noise;
                acc_log.push_back(cyc);
            end
        end
    end

    task automatic set_ent(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int w, input logic [DW-1:0] rd,
                           input logic e, input logic nz);
        tbl[i].wr    = wr;
        tbl[i].addr  = a;
        tbl[i].wdata = wd;
        tbl[i].waits = w;
        tbl[i].rdata = rd;
        tbl[i].err   = e;
        tbl[i].noise = nz;
    endtask

    task automatic send(input int idx, input logic keep);
        int n;
        n         = 0;
        drv_idx   = idx;
        cmd_valid = 1'b1;
        cmd_write = tbl[idx].wr;
        cmd_addr  = tbl[idx].addr;
        cmd_wdata = tbl[idx].wdata;
        @(negedge PCLK);
        while (!cmd_ready && n < 100) begin
            n++;
            @(negedge PCLK);
        end
        chk("accept_wait", 32'(cmd_ready), 1);
        @(posedge PCLK);
        #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        @(negedge PCLK);
        while (!rsp_valid && n < 200) begin
            n++;
            @(negedge PCLK);
        end
        chk("rsp_arrives", 32'(rsp_valid), 1);
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        int nrsp;
        set_ent(0, 1'b1, 5'h03, 8'hA5, 0, 8'h00, 1'b0, 1'b0);
        set_ent(1, 1'b0, 5'h1F, 8'hC3, 2, 8'h3C, 1'b0, 1'b0);
        set_ent(2, 1'b0, 5'h0A, 8'h5A, 0, 8'h55, 1'b0, 1'b1);
        set_ent(3, 1'b0, 5'h0B, 8'h00, 1, 8'h66, 1'b1, 1'b0);
        set_ent(4, 1'b1, 5'h11, 8'h01, 0, 8'h00, 1'b0, 1'b0);
        set_ent(5, 1'b0, 5'h12, 8'h99, 0, 8'h77, 1'b0, 1'b0);
        set_ent(6, 1'b1, 5'h13, 8'hFF, 0, 8'h00, 1'b1, 1'b0);
        set_ent(7, 1'b0, 5'h14, 8'h00, 0, 8'h88, 1'b0, 1'b0);
        set_ent(8, 1'b0, 5'h07, 8'h00, 6, 8'h44, 1'b0, 1'b0);
        set_ent(9, 1'b1, 5'h1A, 8'h5C, 0, 8'h00, 1'b0, 1'b0);
        set_ent(10, 1'b0, 5'h1C, 8'h00, 1000, 8'hAA, 1'b0, 1'b0);

        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(posedge PCLK);
        #1;

        for (int i = 0; i < 4; i++) begin
            send(i, 1'b0);
            wait_rsp();
        end
        send(4, 1'b1);
        send(5, 1'b1);
        send(6, 1'b1);
        send(7, 1'b0);
        wait_rsp();

        // Reset while the slave is still inserting wait states.
        send(8, 1'b0);
        @(posedge PCLK);
        #1;
        @(posedge PCLK);
        #1;
        chk("pre_rst_penable", 32'(PENABLE), 1);
        PRESETn = 1'b0;
        #1;
        chk("rst_async_psel", 32'(PSEL), 0);
        chk("rst_async_penable", 32'(PENABLE), 0);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);
        chk("post_rst_ready", 32'(cmd_ready), 1);
        @(posedge PCLK);
        #1;
        send(9, 1'b0);
        wait_rsp();
        nrsp = 9;
`ifdef APB_MASTER_TIMEOUT_EN
        send(10, 1'b0);
        wait_rsp();
        nrsp = 10;
`endif
        repeat (3) @(posedge PCLK);
        #1;

        chk("rsp_count", 32'(rsp_rd.size()), 32'(nrsp));
        if (rsp_rd.size() >= 9 && pen_log.size() >= 9 && acc_log.size() >= 10) begin
            chk("w0_psel_cycles", 32'(psel_log[0]), 2);
            chk("w0_penable_cycles", 32'(pen_log[0]), 1);
            chk("w0_latency", 32'(rsp_cy[0] - acc_log[0]), 3);
            chk("w0_err", 32'(rsp_er[0]), 0);
            chk("w0_rdata", 32'(rsp_rd[0]), 0);
            chk("r1_access_cycles", 32'(pen_log[1]), 3);
            chk("r1_latency", 32'(rsp_cy[1] - acc_log[1]), 5);
            chk("r1_rdata", 32'(rsp_rd[1]), 32'h3C);
            chk("r2_setup_err_ignored", 32'(rsp_er[2]), 0);
            chk("r2_rdata", 32'(rsp_rd[2]), 32'h55);
            chk("r3_err", 32'(rsp_er[3]), 1);
            chk("r3_rdata", 32'(rsp_rd[3]), 32'h66);
            chk("b2b_gap_45", 32'(acc_log[5] - acc_log[4]), 3);
            chk("b2b_gap_56", 32'(acc_log[6] - acc_log[5]), 3);
            chk("b2b_gap_67", 32'(acc_log[7] - acc_log[6]), 3);
            chk("b2b_rdata_4", 32'(rsp_rd[4]), 0);
            chk("b2b_rdata_5", 32'(rsp_rd[5]), 32'h77);
            chk("b2b_err_6", 32'(rsp_er[6]), 1);
            chk("b2b_rdata_7", 32'(rsp_rd[7]), 32'h88);
            chk("post_rst_err", 32'(rsp_er[8]), 0);
            chk("post_rst_rdata", 32'(rsp_rd[8]), 0);
        end
`ifdef APB_MASTER_TIMEOUT_EN
        if (rsp_rd.size() >= 10 && pen_log.size() >= 10) begin
            chk("tmo_access_cycles", 32'(pen_log[9]), 16);
            chk("tmo_err", 32'(rsp_er[9]), 1);
            chk("tmo_rdata", 32'(rsp_rd[9]), 0);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
